// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters,
// IF/ID prediction carry registers, ID-stage mispredict detection and statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pred_pc_o,
  output logic              pred_hit_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              id_pred_taken_o,
  output logic [ADDR_W-1:0] id_pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [STAT_W-1:0] br_count_o,
  output logic [STAT_W-1:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  // Counter encodings: reset is weakly not-taken, allocation is weakly taken.
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(2 ** (CNT_W - 1));

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              valid_q  [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  // ---------------------------------------------------------------------------
  // IF-stage lookup (reads the table state before any same-cycle update)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_taken;

  assign lk_idx     = pc_i[IDX_W+1:2];
  assign lk_tag     = pc_i[ADDR_W-1:IDX_W+2];
  assign pred_hit_o = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken   = pred_hit_o && cnt_q[lk_idx][CNT_W-1];
  assign pred_pc_o  = lk_taken ? target_q[lk_idx] : pc_i + ADDR_W'(4);

  // ---------------------------------------------------------------------------
  // IF/ID prediction carry; flush wins over stall
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_pred_taken_o  <= 1'b0;
      id_pred_target_o <= '0;
    end else if (flush_i) begin
      id_pred_taken_o  <= 1'b0;
      id_pred_target_o <= '0;
    end else if (!stall_i) begin
      id_pred_taken_o  <= lk_taken;
      id_pred_target_o <= pred_pc_o;
    end
  end

  // ---------------------------------------------------------------------------
  // ID-stage resolution
  // ---------------------------------------------------------------------------
  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != id_pred_taken_o) ||
                         (upd_taken_i && (upd_target_i != id_pred_target_o)));

  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);

  // ---------------------------------------------------------------------------
  // Table update
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             tbl_we;
  logic [CNT_W-1:0] cnt_nxt;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // A not-taken miss leaves the entry alone; everything else writes it.
  assign tbl_we = upd_valid_i && (up_hit || upd_taken_i);

  // NOTE: cnt_nxt gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_nxt = cnt_q[up_idx];
    if (!up_hit) begin
      cnt_nxt = CNT_ALLOC;
    end else if (upd_taken_i) begin
      if (cnt_nxt != CNT_MAX) cnt_nxt = cnt_nxt + CNT_W'(1);
    end else begin
      if (cnt_nxt != '0) cnt_nxt = cnt_nxt - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RST;
      end
    end else if (tbl_we) begin
      valid_q[up_idx] <= 1'b1;
      cnt_q[up_idx]   <= cnt_nxt;
    end
  end

  // NOTE: tag/target storage has no reset; the valid bit alone qualifies its contents.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else if (upd_valid_i) begin
      if (br_count_o != STAT_MAX) br_count_o <= br_count_o + STAT_W'(1);
      if (mispredict_o && (mispred_count_o != STAT_MAX))
        mispred_count_o <= mispred_count_o + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CNT_W=2, ADDR_W=32, STAT_W=4).
module tb_branch_predictor;

  localparam int ADDR_W = 32;
  localparam int STAT_W = 4;
  localparam int STAT_MAX = 15;

  typedef enum {SIG_HIT, SIG_PRED_PC, SIG_ID_TAKEN, SIG_ID_TARGET,
                SIG_MISP, SIG_REDIR, SIG_BR, SIG_MP} sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] pc_i;
  logic [ADDR_W-1:0] pred_pc_o;
  logic              pred_hit_o;
  logic              stall_i;
  logic              flush_i;
  logic              id_pred_taken_o;
  logic [ADDR_W-1:0] id_pred_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              mispredict_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [STAT_W-1:0] br_count_o;
  logic [STAT_W-1:0] mispred_count_o;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  branch_predictor #(
    .ENTRIES(16), .CNT_W(2), .ADDR_W(ADDR_W), .STAT_W(STAT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_i            (pc_i),
    .pred_pc_o       (pred_pc_o),
    .pred_hit_o      (pred_hit_o),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .id_pred_taken_o (id_pred_taken_o),
    .id_pred_target_o(id_pred_target_o),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .mispredict_o    (mispredict_o),
    .redirect_pc_o   (redirect_pc_o),
    .br_count_o      (br_count_o),
    .mispred_count_o (mispred_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SIG_HIT:       return {31'd0, pred_hit_o};
      SIG_PRED_PC:   return pred_pc_o;
      SIG_ID_TAKEN:  return {31'd0, id_pred_taken_o};
      SIG_ID_TARGET: return id_pred_target_o;
      SIG_MISP:      return {31'd0, mispredict_o};
      SIG_REDIR:     return redirect_pc_o;
      SIG_BR:        return 32'(br_count_o);
      default:       return 32'(mispred_count_o);
    endcase
  endfunction

  task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_lookup(input string tag, input logic hit, input logic [31:0] pc);
    expect_sig({tag, "_hit"}, SIG_HIT, {31'd0, hit});
    expect_sig({tag, "_pred"}, SIG_PRED_PC, pc);
    drain();
  endtask

  task automatic expect_id(input string tag, input logic taken, input logic [31:0] tgt);
    expect_sig({tag, "_idtk"}, SIG_ID_TAKEN, {31'd0, taken});
    expect_sig({tag, "_idtg"}, SIG_ID_TARGET, tgt);
    drain();
  endtask

  task automatic expect_counts(input string tag);
    expect_sig({tag, "_br"}, SIG_BR, 32'(exp_br));
    expect_sig({tag, "_mp"}, SIG_MP, 32'(exp_mp));
    drain();
  endtask

  // Drive one resolution for a cycle; mispredict/redirect are checked before the edge.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic exp_misp,
                         input logic [31:0] exp_redir);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
    #1;
    expect_sig({tag, "_misp"}, SIG_MISP, {31'd0, exp_misp});
    if (exp_misp) expect_sig({tag, "_redir"}, SIG_REDIR, exp_redir);
    drain();
    step();
    upd_valid_i = 1'b0;
    if (exp_br < STAT_MAX) exp_br++;
    if (exp_misp && exp_mp < STAT_MAX) exp_mp++;
  endtask

  initial begin
    rst_i        = 1'b1;
    pc_i         = 32'h40;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    upd_valid_i  = 1'b0;
    upd_pc_i     = '0;
    upd_taken_i  = 1'b0;
    upd_target_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;

    // Reset state
    expect_lookup("rst", 1'b0, 32'h44);
    expect_id("rst", 1'b0, 32'h0);
    expect_counts("rst");

    // Cold taken branch allocates the entry
    resolve("cold", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    expect_lookup("cold_after", 1'b1, 32'h80);
    expect_id("cold_after", 1'b0, 32'h44);
    expect_counts("cold_after");

    // Hysteresis: reinforce to strongly taken, then two not-taken resolutions
    resolve("reinf", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    expect_lookup("strong", 1'b1, 32'h80);
    resolve("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h44);
    expect_lookup("after_nt1", 1'b1, 32'h80);
    resolve("nt2", 32'h40, 1'b0, 32'h0, 1'b1, 32'h44);
    expect_lookup("after_nt2", 1'b1, 32'h44);

    // Four taken updates saturate the counter without wrapping
    resolve("tk1", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    resolve("tk2", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    resolve("tk3", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    resolve("tk4", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_lookup("sat", 1'b1, 32'h80);
    resolve("sat_nt", 32'h40, 1'b0, 32'h0, 1'b1, 32'h44);
    expect_lookup("nowrap", 1'b1, 32'h80);

    // Alias on index 0 with a different tag
    pc_i = 32'h80;
    #1;
    expect_lookup("alias", 1'b0, 32'h84);
    resolve("alias_upd", 32'h80, 1'b1, 32'hC0, 1'b1, 32'hC0);
    pc_i = 32'h40;
    #1;
    expect_lookup("evicted", 1'b0, 32'h44);
    pc_i = 32'h80;
    #1;
    expect_lookup("replaced", 1'b1, 32'hC0);
    expect_counts("mid");

    // Pipeline carry: load, stall-hold, flush-over-stall
    step();
    expect_id("load", 1'b1, 32'hC0);
    stall_i = 1'b1;
    pc_i    = 32'h100;
    step();
    expect_id("stall1", 1'b1, 32'hC0);
    step();
    expect_id("stall2", 1'b1, 32'hC0);
    flush_i = 1'b1;
    step();
    expect_id("flush", 1'b0, 32'h0);
    flush_i = 1'b0;
    stall_i = 1'b0;
    pc_i    = 32'h80;
    step();
    expect_id("reload", 1'b1, 32'hC0);
    resolve("correct", 32'h80, 1'b1, 32'hC0, 1'b0, 32'h0);
    expect_counts("correct");

    // Statistics saturation with a steady stream of mispredicts
    pc_i = 32'h500;
    step();
    for (int i = 0; i < 20; i++) begin
      resolve("satloop", 32'h604, 1'b1, 32'h900, 1'b1, 32'h900);
    end
    expect_counts("stat_sat");

    // Asynchronous reset in the middle of an update
    pc_i = 32'h604;
    #1;
    expect_lookup("pre_rst", 1'b1, 32'h900);
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h604;
    upd_taken_i  = 1'b1;
    upd_target_i = 32'h900;
    #2;
    rst_i = 1'b1;
    #1;
    exp_br = 0;
    exp_mp = 0;
    expect_lookup("async_rst", 1'b0, 32'h608);
    expect_id("async_rst", 1'b0, 32'h0);
    expect_counts("async_rst");
    #1;
    upd_valid_i = 1'b0;
    rst_i       = 1'b0;
    step();
    expect_lookup("post_rst", 1'b0, 32'h608);
    expect_counts("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
